// File: rtl/kickback_match_gen.sv
// Kickback-point detector for the BoundFlasher LED sequencer: combinational match
// plus registered rising-edge pulse, last-point latch and saturating event count.
module kickback_match_gen #(
  parameter int unsigned CNT_W      = 5,
  parameter int unsigned KB_POINT_A = 5,
  parameter int unsigned KB_POINT_B = 10,
  parameter int unsigned EVT_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flick,
  input  logic [CNT_W-1:0]     counter,
  output logic                 kickback_match,
  output logic                 kickback_pulse,
  output logic                 kickback_point,
  output logic [EVT_CNT_W-1:0] kickback_cnt
);

  localparam logic [CNT_W-1:0]     POINT_A = CNT_W'(KB_POINT_A);
  localparam logic [CNT_W-1:0]     POINT_B = CNT_W'(KB_POINT_B);
  localparam logic [EVT_CNT_W-1:0] CNT_MAX = '1;

  logic at_a_c;
  logic at_b_c;
  logic rise_c;
  logic match_d;

  // Full-width equality so out-of-range positions never alias onto a kickback lamp.
  always_comb begin
    at_a_c         = (counter == POINT_A);
    at_b_c         = (counter == POINT_B);
    kickback_match = flick & (at_a_c | at_b_c);
    rise_c         = kickback_match & ~match_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_d        <= 1'b0;
      kickback_pulse <= 1'b0;
      kickback_point <= 1'b0;
      kickback_cnt   <= '0;
    end else begin
      match_d        <= kickback_match;
      kickback_pulse <= rise_c;
      if (rise_c) begin
        // Point A wins when both points coincide.
        kickback_point <= at_b_c & ~at_a_c;
        if (kickback_cnt != CNT_MAX) begin
          kickback_cnt <= kickback_cnt + EVT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_kickback_match_gen.sv
// Directed bench for kickback_match_gen: hand-computed vectors checked with
// immediate assertions, plus a second instance with coincident points.
module tb_kickback_match_gen;

  logic       clk;
  logic       rst_n;
  logic       flick;
  logic [4:0] counter;
  logic       kickback_match;
  logic       kickback_pulse;
  logic       kickback_point;
  logic [7:0] kickback_cnt;

  logic       flick2;
  logic [4:0] counter2;
  logic       match2;
  logic       pulse2;
  logic       point2;
  logic [1:0] cnt2;

  int vectors;
  int miscompares;

  kickback_match_gen #(.CNT_W(5), .KB_POINT_A(5), .KB_POINT_B(10), .EVT_CNT_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flick          (flick),
    .counter        (counter),
    .kickback_match (kickback_match),
    .kickback_pulse (kickback_pulse),
    .kickback_point (kickback_point),
    .kickback_cnt   (kickback_cnt)
  );

  kickback_match_gen #(.CNT_W(5), .KB_POINT_A(7), .KB_POINT_B(7), .EVT_CNT_W(2)) dut_same (
    .clk            (clk),
    .rst_n          (rst_n),
    .flick          (flick2),
    .counter        (counter2),
    .kickback_match (match2),
    .kickback_pulse (pulse2),
    .kickback_point (point2),
    .kickback_cnt   (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag, input logic p, input logic pt, input logic [7:0] c);
    chk1({tag, ".pulse"}, kickback_pulse, p);
    chk1({tag, ".point"}, kickback_point, pt);
    chk8({tag, ".cnt"}, kickback_cnt, c);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    flick    = 1'b0;
    counter  = 5'd0;
    flick2   = 1'b0;
    counter2 = 5'd0;
    #3;
    chk1("rst.match", kickback_match, 1'b0);
    chk_regs("rst", 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // flick low: lamp 5 must not match
    step(); chk_regs("idle0", 1'b0, 1'b0, 8'd0);
    counter = 5'd5; #1;
    chk1("idle5.match", kickback_match, 1'b0);
    step(); chk_regs("idle5", 1'b0, 1'b0, 8'd0);
    counter = 5'd0; #1;
    chk1("idle0b.match", kickback_match, 1'b0);
    step(); chk_regs("idle0b", 1'b0, 1'b0, 8'd0);

    // first kickback at point A
    flick = 1'b1; #1;
    chk1("a0.match", kickback_match, 1'b0);
    step();
    counter = 5'd5; #1;
    chk1("a5.match", kickback_match, 1'b1);
    chk1("a5.pulse_early", kickback_pulse, 1'b0);
    step(); chk_regs("a5.edge", 1'b1, 1'b0, 8'd1);
    step(); chk_regs("a5.hold1", 1'b0, 1'b0, 8'd1);
    step(); chk_regs("a5.hold2", 1'b0, 1'b0, 8'd1);

    // back to 0 then point B
    counter = 5'd0; #1;
    chk1("b0.match", kickback_match, 1'b0);
    step();
    counter = 5'd10; #1;
    chk1("b10.match", kickback_match, 1'b1);
    step(); chk_regs("b10.edge", 1'b1, 1'b1, 8'd2);
    step(); chk_regs("b10.hold", 1'b0, 1'b1, 8'd2);

    // direct 10 -> 5 with match continuously high: no new pulse
    counter = 5'd5; #1;
    chk1("direct.match", kickback_match, 1'b1);
    step(); chk_regs("direct", 1'b0, 1'b1, 8'd2);

    // non-kickback positions including out-of-range values
    counter = 5'd15; #1; chk1("c15.match", kickback_match, 1'b0); step();
    chk_regs("c15", 1'b0, 1'b1, 8'd2);
    counter = 5'd16; #1; chk1("c16.match", kickback_match, 1'b0); step();
    counter = 5'd21; #1; chk1("c21.match", kickback_match, 1'b0); step();
    counter = 5'd26; #1; chk1("c26.match", kickback_match, 1'b0); step();
    counter = 5'd31; #1; chk1("c31.match", kickback_match, 1'b0); step();
    chk_regs("c31", 1'b0, 1'b1, 8'd2);

    // flick drop and re-rise at a kickback point
    counter = 5'd5;
    step(); chk_regs("rr.first", 1'b1, 1'b0, 8'd3);
    flick = 1'b0;
    step(); chk_regs("rr.low", 1'b0, 1'b0, 8'd3);
    flick = 1'b1;
    step(); chk_regs("rr.second", 1'b1, 1'b0, 8'd4);
    flick = 1'b0;
    step();
    flick = 1'b1; counter = 5'd10;
    step(); chk_regs("pre_rst", 1'b1, 1'b1, 8'd5);

    // asynchronous reset mid-sequence with match held high
    #1 rst_n = 1'b0;
    #1;
    chk_regs("mid_rst", 1'b0, 1'b0, 8'd0);
    chk1("mid_rst.match", kickback_match, 1'b1);
    step(); chk_regs("in_rst", 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_regs("post_rst", 1'b1, 1'b1, 8'd1);
    step(); chk_regs("post_rst.hold", 1'b0, 1'b1, 8'd1);

    // saturation: 259 more rising edges at point A
    counter = 5'd5;
    for (int i = 0; i < 253; i++) begin
      flick = 1'b0; step();
      flick = 1'b1; step();
    end
    chk_regs("sat254", 1'b1, 1'b0, 8'd254);
    flick = 1'b0; step();
    flick = 1'b1; step();
    chk_regs("sat255", 1'b1, 1'b0, 8'd255);
    for (int i = 0; i < 5; i++) begin
      flick = 1'b0; step();
      flick = 1'b1; step();
    end
    chk_regs("sat_hold", 1'b1, 1'b0, 8'd255);
    flick = 1'b0; step();
    chk_regs("sat_idle", 1'b0, 1'b0, 8'd255);

    // coincident points: point A priority, 2-bit saturation
    flick2 = 1'b1; counter2 = 5'd7; #1;
    chk1("same.match", match2, 1'b1);
    step();
    chk1("same.pulse", pulse2, 1'b1);
    chk1("same.point", point2, 1'b0);
    chk8("same.cnt1", 8'(cnt2), 8'd1);
    for (int i = 0; i < 3; i++) begin
      flick2 = 1'b0; step();
      flick2 = 1'b1; step();
    end
    chk8("same.sat", 8'(cnt2), 8'd3);
    chk1("same.point2", point2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
